// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction, extracts load data, drives the
// regfile write port and decode bypass. Optional WB_PERF_EN adds perf_retired.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [31:0]       mem_pc,
  input  logic              mem_rf_wen,
  input  logic [ADDR_W-1:0] mem_rf_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              mem_load,
  input  logic [2:0]        mem_load_type,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              flush,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_addr_w,
  output logic [DATA_W-1:0] rf_data_w,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              ld_pending,
  output logic [ADDR_W-1:0] ld_pending_addr,
`ifdef WB_PERF_EN
  output logic [31:0]       perf_retired,
`endif
  output logic              wb_valid,
  output logic [31:0]       wb_pc
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_COMMIT,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [31:0]       r_pc;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_result;
  logic [2:0]        r_load_type;

  logic              w_accept;
  logic              w_ld_done;
  logic              w_commit;
  logic              w_wr_ok;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ld_data;

  // Handshake and next state
  always_comb begin
    w_state_nx = r_state;
    mem_ready  = 1'b0;
    w_accept   = 1'b0;
    w_ld_done  = 1'b0;
    case (r_state)
      S_EMPTY:  mem_ready = !rst && !flush;
      S_COMMIT: mem_ready = !flush;
      default:  mem_ready = 1'b0;
    endcase
    w_accept = mem_valid && mem_ready;
    case (r_state)
      S_EMPTY: begin
        if (w_accept)
          w_state_nx = mem_load ? S_WAIT : S_COMMIT;
      end
      S_WAIT: begin
        if (flush) begin
          w_state_nx = S_DRAIN;
        end else if (dmem_rvalid) begin
          w_ld_done  = 1'b1;
          w_state_nx = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (w_accept)
          w_state_nx = mem_load ? S_WAIT : S_COMMIT;
        else
          w_state_nx = S_EMPTY;
      end
      S_DRAIN: begin
        if (dmem_rvalid)
          w_state_nx = S_EMPTY;
      end
      default: w_state_nx = S_EMPTY;
    endcase
  end

  // Little-endian lane select; lh/lhu ignore result[0]
  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_result[1:0])
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_result[1] ? dmem_rdata[31:16]
                         : dmem_rdata[15:0];
  end

  always_comb begin
    w_ld_data = dmem_rdata;
    case (r_load_type)
      3'b000:
        w_ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b001:
        w_ld_data = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b100:
        w_ld_data = {{(DATA_W-8){1'b0}}, w_byte};
      3'b101:
        w_ld_data = {{(DATA_W-16){1'b0}}, w_half};
      default:
        w_ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_EMPTY;
    else
      r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= '0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_result    <= '0;
      r_load_type <= '0;
    end else if (w_accept) begin
      r_pc        <= mem_pc;
      r_wen       <= mem_rf_wen;
      r_addr      <= mem_rf_addr;
      r_result    <= mem_result;
      r_load_type <= mem_load_type;
    end else if (w_ld_done) begin
      r_result    <= w_ld_data;
    end
  end

`ifdef WB_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_perf <= '0;
    else if (r_state == S_COMMIT)
      r_perf <= r_perf + 32'd1;
  end

  assign perf_retired = r_perf;
`endif

  // Outputs depend only on state and latched registers
  assign w_commit = (r_state == S_COMMIT);
  assign w_wr_ok  = r_wen && (r_addr != '0);

  always_comb begin
    wb_valid        = w_commit;
    wb_pc           = w_commit ? r_pc : '0;
    rf_wen          = w_commit && w_wr_ok;
    rf_addr_w       = w_commit ? r_addr : '0;
    rf_data_w       = w_commit ? r_result : '0;
    fwd_valid       = rf_wen;
    fwd_addr        = rf_addr_w;
    fwd_data        = rf_data_w;
    ld_pending      = (r_state == S_WAIT) && w_wr_ok;
    ld_pending_addr = ld_pending ? r_addr : '0;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: occupancy-level reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_pc;
  logic        mem_rf_wen;
  logic [4:0]  mem_rf_addr;
  logic [31:0] mem_result;
  logic        mem_load;
  logic [2:0]  mem_load_type;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        flush;
  logic        rf_wen;
  logic [4:0]  rf_addr_w;
  logic [31:0] rf_data_w;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        ld_pending;
  logic [4:0]  ld_pending_addr;
  logic        wb_valid;
  logic [31:0] wb_pc;
`ifdef WB_PERF_EN
  logic [31:0] perf_retired;
`endif

  int checks = 0;
  int failures = 0;

  wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_pc(mem_pc),
    .mem_rf_wen(mem_rf_wen),
    .mem_rf_addr(mem_rf_addr),
    .mem_result(mem_result),
    .mem_load(mem_load),
    .mem_load_type(mem_load_type),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .flush(flush),
    .rf_wen(rf_wen),
    .rf_addr_w(rf_addr_w),
    .rf_data_w(rf_data_w),
    .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr),
    .fwd_data(fwd_data),
    .ld_pending(ld_pending),
    .ld_pending_addr(ld_pending_addr),
`ifdef WB_PERF_EN
    .perf_retired(perf_retired),
`endif
    .wb_valid(wb_valid),
    .wb_pc(wb_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: what the stage holds, not how it sequences.
  bit          m_held;
  bit          m_loaded;
  bit          m_orphan;
  logic [31:0] m_pc;
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_res;
  logic [2:0]  m_t;
  logic [31:0] m_perf;

  function automatic logic [31:0] m_ext(
    input logic [31:0] d,
    input logic [31:0] a,
    input logic [2:0]  t
  );
    int    size;
    int    sh;
    longint v;
    longint lim;
    bit    sgn;
    size = 4;
    sh = 0;
    sgn = 0;
    if (t == 3'd0 || t == 3'd4) begin
      size = 1;
      sh = a % 4;
    end else if (t == 3'd1 || t == 3'd5) begin
      size = 2;
      sh = ((a / 2) % 2) * 2;
    end
    sgn = (t == 3'd0 || t == 3'd1);
    lim = longint'(1) << (8 * size);
    v = longint'(d >> (8 * sh)) % lim;
    if (sgn && size < 4 && v >= lim / 2)
      v = v - lim;
    return v[31:0];
  endfunction

  function automatic bit m_ready_now();
    return !rst && !flush && !m_orphan &&
           !(m_held && !m_loaded);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_held = 0;
      m_loaded = 0;
      m_orphan = 0;
      m_pc = '0;
      m_wen = 0;
      m_addr = '0;
      m_res = '0;
      m_t = '0;
      m_perf = '0;
    end else begin
      bit acc;
      acc = mem_valid && m_ready_now();
      if (m_held && m_loaded)
        m_perf = m_perf + 32'd1;
      if (m_orphan) begin
        if (dmem_rvalid)
          m_orphan = 0;
      end else if (m_held && !m_loaded) begin
        if (flush) begin
          m_held = 0;
          m_orphan = 1;
        end else if (dmem_rvalid) begin
          m_res = m_ext(dmem_rdata, m_res, m_t);
          m_loaded = 1;
        end
      end else if (acc) begin
        m_held = 1;
        m_loaded = !mem_load;
        m_pc = mem_pc;
        m_wen = mem_rf_wen;
        m_addr = mem_rf_addr;
        m_res = mem_result;
        m_t = mem_load_type;
      end else begin
        m_held = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit c;
    bit w;
    bit p;
    c = m_held && m_loaded;
    w = c && m_wen && (m_addr != 0);
    p = m_held && !m_loaded && m_wen &&
        (m_addr != 0);
    cmp("mem_ready", 64'(mem_ready),
        64'(m_ready_now()));
    cmp("wb_valid", 64'(wb_valid), 64'(c));
    cmp("wb_pc", 64'(wb_pc), 64'(c ? m_pc : 0));
    cmp("rf_wen", 64'(rf_wen), 64'(w));
    cmp("rf_addr_w", 64'(rf_addr_w),
        64'(c ? m_addr : 5'd0));
    cmp("rf_data_w", 64'(rf_data_w),
        64'(c ? m_res : 0));
    cmp("fwd_valid", 64'(fwd_valid), 64'(w));
    cmp("fwd_addr", 64'(fwd_addr),
        64'(c ? m_addr : 5'd0));
    cmp("fwd_data", 64'(fwd_data),
        64'(c ? m_res : 0));
    cmp("ld_pending", 64'(ld_pending), 64'(p));
    cmp("ld_pending_addr", 64'(ld_pending_addr),
        64'(p ? m_addr : 5'd0));
`ifdef WB_PERF_EN
    cmp("perf_retired", 64'(perf_retired),
        64'(m_perf));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] pc,
                     input logic        wen,
                     input logic [4:0]  addr,
                     input logic [31:0] res,
                     input logic        ld,
                     input logic [2:0]  t);
    mem_valid = 1'b1;
    mem_pc = pc;
    mem_rf_wen = wen;
    mem_rf_addr = addr;
    mem_result = res;
    mem_load = ld;
    mem_load_type = t;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
  endtask

  logic [2:0]  lt_t [7];
  logic [31:0] lt_a [7];
  logic [31:0] lt_e [7];

  initial begin
    lt_t[0] = 3'd0; lt_a[0] = 32'h1001;
    lt_e[0] = 32'hFFFFFF83;
    lt_t[1] = 3'd4; lt_a[1] = 32'h1001;
    lt_e[1] = 32'h00000083;
    lt_t[2] = 3'd5; lt_a[2] = 32'h1002;
    lt_e[2] = 32'h00001122;
    lt_t[3] = 3'd1; lt_a[3] = 32'h1000;
    lt_e[3] = 32'hFFFF8344;
    lt_t[4] = 3'd2; lt_a[4] = 32'h1003;
    lt_e[4] = 32'h11228344;
    lt_t[5] = 3'd0; lt_a[5] = 32'h1003;
    lt_e[5] = 32'h00000011;
    lt_t[6] = 3'd7; lt_a[6] = 32'h1001;
    lt_e[6] = 32'h11228344;

    rst = 1'b1;
    mem_valid = 0;
    mem_pc = '0;
    mem_rf_wen = 0;
    mem_rf_addr = '0;
    mem_result = '0;
    mem_load = 0;
    mem_load_type = '0;
    dmem_rvalid = 0;
    dmem_rdata = '0;
    flush = 0;
    repeat (2) cyc();
    cmp("rst_ready", 64'(mem_ready), 0);
    cmp("rst_wbv", 64'(wb_valid), 0);
    rst = 1'b0;
    #1;
    cmp("post_rst_ready", 64'(mem_ready), 1);
    cmp("post_rst_rfwen", 64'(rf_wen), 0);

    // ALU op to r5
    put(32'h100, 1, 5'd5, 32'h1234ABCD, 0, 0);
    cyc();
    idle();
    #1;
    cmp("addu_wbv", 64'(wb_valid), 1);
    cmp("addu_wen", 64'(rf_wen), 1);
    cmp("addu_addr", 64'(rf_addr_w), 5);
    cmp("addu_data", 64'(rf_data_w), 64'h1234ABCD);
    cmp("addu_fwd", 64'(fwd_valid), 1);
    cmp("addu_pc", 64'(wb_pc), 64'h100);
    cyc();
    cmp("addu_after", 64'(rf_wen), 0);

    // Load extraction table, rdata 0x11228344
    for (int i = 0; i < 7; i++) begin
      put(32'h200 + 32'(i), 1, 5'd3, lt_a[i], 1, lt_t[i]);
      cyc();
      idle();
      #1;
      cmp("ld_pend", 64'(ld_pending), 1);
      cmp("ld_pend_addr", 64'(ld_pending_addr), 3);
      cmp("ld_ready", 64'(mem_ready), 0);
      cyc();
      dmem_rvalid = 1;
      dmem_rdata = 32'h11228344;
      cyc();
      dmem_rvalid = 0;
      #1;
      cmp("ld_wbv", 64'(wb_valid), 1);
      cmp("ld_wen", 64'(rf_wen), 1);
      cmp("ld_data", 64'(rf_data_w), 64'(lt_e[i]));
      cyc();
    end

    // Write to r0
    put(32'h300, 1, 5'd0, 32'hFFFFFFFF, 0, 0);
    cyc();
    idle();
    #1;
    cmp("r0_wbv", 64'(wb_valid), 1);
    cmp("r0_wen", 64'(rf_wen), 0);
    cmp("r0_fwd", 64'(fwd_valid), 0);
    cyc();

    // Back-to-back ALU ops r1..r4
    for (int i = 1; i <= 4; i++) begin
      put(32'h400 + 32'(4 * i), 1, 5'(i),
          32'hA0 + 32'(i), 0, 0);
      #1;
      cmp("b2b_ready", 64'(mem_ready), 1);
      if (i > 1) begin
        cmp("b2b_wbv", 64'(wb_valid), 1);
        cmp("b2b_addr", 64'(rf_addr_w), 64'(i - 1));
      end
      cyc();
    end
    idle();
    #1;
    cmp("b2b_last", 64'(rf_addr_w), 4);
    cmp("b2b_lastd", 64'(rf_data_w), 64'hA4);
    cyc();
    cmp("b2b_done", 64'(wb_valid), 0);

    // Flush during WAIT, late response discarded
    put(32'h500, 1, 5'd7, 32'h2000, 1, 3'd2);
    cyc();
    idle();
    #1;
    cmp("fl_pend", 64'(ld_pending), 1);
    flush = 1;
    #1;
    cmp("fl_ready", 64'(mem_ready), 0);
    cyc();
    flush = 0;
    #1;
    cmp("drain_ready", 64'(mem_ready), 0);
    cmp("drain_pend", 64'(ld_pending), 0);
    cyc();
    cyc();
    dmem_rvalid = 1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    cmp("drain_rv_ready", 64'(mem_ready), 0);
    cmp("drain_rv_wen", 64'(rf_wen), 0);
    cyc();
    dmem_rvalid = 0;
    #1;
    cmp("drain_done_ready", 64'(mem_ready), 1);
    cmp("drain_done_wbv", 64'(wb_valid), 0);
    cyc();

    // Flush blocks acceptance in EMPTY
    put(32'h600, 1, 5'd8, 32'h55, 0, 0);
    flush = 1;
    #1;
    cmp("fl_empty_ready", 64'(mem_ready), 0);
    cyc();
    idle();
    flush = 0;
    #1;
    cmp("fl_empty_wbv", 64'(wb_valid), 0);

    // Flush does not cancel a commit
    put(32'h700, 1, 5'd6, 32'h66, 0, 0);
    cyc();
    idle();
    flush = 1;
    #1;
    cmp("fl_cm_wbv", 64'(wb_valid), 1);
    cmp("fl_cm_wen", 64'(rf_wen), 1);
    cmp("fl_cm_ready", 64'(mem_ready), 0);
    cyc();
    flush = 0;

    // Reset in the middle of WAIT
    put(32'h800, 1, 5'd9, 32'h3000, 1, 3'd2);
    cyc();
    idle();
    #1;
    cmp("rw_pend", 64'(ld_pending), 1);
    rst = 1;
    #1;
    cmp("rw_pend0", 64'(ld_pending), 0);
    cmp("rw_paddr0", 64'(ld_pending_addr), 0);
    cmp("rw_ready0", 64'(mem_ready), 0);
    cmp("rw_wbv0", 64'(wb_valid), 0);
    cyc();
    rst = 0;
    dmem_rvalid = 1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    cmp("rw_ready1", 64'(mem_ready), 1);
    cyc();
    dmem_rvalid = 0;
    #1;
    cmp("rw_late_wbv", 64'(wb_valid), 0);
    cmp("rw_late_wen", 64'(rf_wen), 0);

`ifdef WB_PERF_EN
    rst = 1;
    #1;
    rst = 0;
    #1;
    cmp("perf_zero", 64'(perf_retired), 0);
    for (int i = 0; i < 5; i++) begin
      put(32'h900 + 32'(4 * i), 1,
          (i == 1) ? 5'd0 : 5'(i + 1),
          32'(i), 0, 0);
      cyc();
    end
    idle();
    cyc();
    cmp("perf_five", 64'(perf_retired), 5);
    rst = 1;
    #1;
    cmp("perf_rst", 64'(perf_retired), 0);
    rst = 0;
`endif

    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the MIPS core. Sits between the MEM stage / data memory and the register file write port.
- Holds one instruction. Waits for load data when needed, then extracts and sign/zero-extends the byte, half or word.
- Drives the regfile write port (rf_wen / rf_addr_w / rf_data_w) for exactly one cycle per committed instruction.
- Provides a bypass path and load-pending info to decode, because a regfile read in the same cycle as a write returns the old value.

Parameters:
- DATA_W, 32, datapath and register width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  wb_stage accepts this cycle; transfer happens when mem_valid && mem_ready.
- mem_pc  in  32  PC of the presented instruction.
- mem_rf_wen  in  1  instruction writes a register.
- mem_rf_addr  in  ADDR_W  destination register.
- mem_result  in  DATA_W  ALU result, or effective address for loads.
- mem_load  in  1  instruction is a load.
- mem_load_type  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; any other code is treated as lw.
- dmem_rvalid  in  1  load data valid this cycle.
- dmem_rdata  in  DATA_W  raw aligned memory word.
- flush  in  1  kill the uncommitted load and block acceptance.
- rf_wen  out  1  regfile write enable.
- rf_addr_w  out  ADDR_W  regfile write address.
- rf_data_w  out  DATA_W  regfile write data.
- fwd_valid  out  1  bypass valid, equal to rf_wen.
- fwd_addr  out  ADDR_W  bypass address, equal to rf_addr_w.
- fwd_data  out  DATA_W  bypass data, equal to rf_data_w.
- ld_pending  out  1  a load is waiting for data; decode stalls on a match.
- ld_pending_addr  out  ADDR_W  destination of the pending load.
- wb_valid  out  1  instruction commits this cycle.
- wb_pc  out  32  PC of the committing instruction.

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high.
- Reset: state EMPTY. All internal registers cleared to 0. Every output is 0 except mem_ready, which is 1 once rst deasserts.
- State EMPTY:
  - mem_ready = !flush.
  - On accept: latch pc, wen, addr, result, load, load_type.
  - Non-load goes to COMMIT; load goes to WAIT.
- State WAIT:
  - mem_ready = 0; ld_pending = mem_rf_wen_latched && addr != 0.
  - If flush: go to DRAIN. Flush has priority over dmem_rvalid in the same cycle, and that response is discarded.
  - Else if dmem_rvalid: capture the extracted load data into the result register and go to COMMIT.
- State COMMIT (exactly one cycle):
  - wb_valid = 1; wb_pc = latched pc.
  - rf_wen = latched wen && addr != 0. rf_addr_w and rf_data_w come from the latched registers.
  - Register 0 is never written, and fwd_valid is 0 for register 0.
  - mem_ready = !flush. Flush never cancels the committing instruction.
  - On accept: go to WAIT or COMMIT per the new instruction's mem_load, giving back-to-back commits at 1 per cycle. Otherwise go to EMPTY.
- State DRAIN:
  - mem_ready = 0; all write outputs 0.
  - On dmem_rvalid: discard the data and go to EMPTY.
- Latency:
  - Non-load accepted at edge N commits in the cycle after N; the regfile writes at the following edge.
  - Load with dmem_rvalid in cycle M commits in cycle M+1.
- Load extraction is little-endian, with off = result[1:0]:
  - lb/lbu take byte off = dmem_rdata[8*off+7 : 8*off].
  - lh/lhu take half result[1]; result[0] is ignored.
  - lw ignores result[1:0].
  - lb/lh sign-extend to DATA_W; lbu/lhu zero-extend.
- Outputs are combinational from state and latched registers only. There is no combinational path from mem_* to rf_* or fwd_*.
- Reset mid-WAIT or mid-DRAIN goes to EMPTY immediately. A late dmem_rvalid after reset is ignored because the state is EMPTY and nothing is latched.

Optional Feature:
- WB_PERF_EN defined: adds output perf_retired (32 bits).
  - Increments by 1 in every COMMIT cycle, including commits with wen=0 or addr 0.
  - Wraps from 0xFFFFFFFF to 0; reset value 0.
- WB_PERF_EN not defined: no counter and no perf_retired port; all other behaviour is identical.

Test Plan:
- Reset, then accept addu to r5, result 0x1234ABCD, wen=1 -> next cycle rf_wen=1, rf_addr_w=5, rf_data_w=0x1234ABCD, fwd_valid=1, wb_valid=1; the cycle after, rf_wen=0.
- lb to r3, result 0x1001, dmem_rdata 0x11228344, rvalid 2 cycles after accept -> ld_pending=1 with addr 3 while waiting, mem_ready=0; commit rf_data_w=0xFFFFFF83. Same stimulus as lbu -> 0x00000083. lhu at 0x1002 -> 0x00001122.
- Instruction writing r0 with result 0xFFFFFFFF -> wb_valid=1, rf_wen=0, fwd_valid=0.
- Four back-to-back ALU ops to r1..r4 with mem_valid held 1 -> four consecutive commit cycles, mem_ready stays 1.
- Load in WAIT, flush=1 for one cycle, rvalid 3 cycles later with 0xDEADBEEF -> no rf_wen, mem_ready=0 until the rvalid cycle, EMPTY afterwards. Also assert rst mid-WAIT -> all outputs 0 immediately.
- With WB_PERF_EN defined: 5 commits (one to r0), then reset -> perf_retired reads 5, then 0.
